coin_emitter: RTL

COIN_EMITTER -- requirements
Module: coin_emitter

---
 rtl/coin_emitter.sv | 106 ++++++++++
 1 files changed

// File: rtl/coin_emitter.sv
// Coin pulse emitter: turns an accepted coin count into a burst of active-low
// pulses on pulse_out, then holds the line idle long enough for the acceptor to commit.
module coin_emitter #(
  parameter int  PULSE_LOW_CYCLES  = 600_000,
  parameter int  PULSE_HIGH_CYCLES = 1_200_000,
  parameter int  COMMIT_GAP_CYCLES = 4_000_000,
  localparam int MAX_PULSE_COUNT   = 50,
  localparam int COIN_WIDTH        = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COIN_WIDTH-1:0] coin_in,
  input  logic                  coin_valid,
  output logic                  coin_ready,
  output logic                  pulse_out,
  output logic                  busy,
  output logic                  done,
  output logic                  reject,
  output logic [1:0]            state_dbg
);

  // Handshake: a request is taken on a rising edge where coin_valid && coin_ready;
  // coin_ready is high only in IDLE, so inputs are ignored for the whole burst.

  localparam int MAX_LH  = (PULSE_LOW_CYCLES > PULSE_HIGH_CYCLES) ? PULSE_LOW_CYCLES : PULSE_HIGH_CYCLES;
  localparam int MAX_CYC = (MAX_LH > COMMIT_GAP_CYCLES) ? MAX_LH : COMMIT_GAP_CYCLES;
  localparam int PHASE_W = $clog2(MAX_CYC) + 1;

  localparam logic [PHASE_W-1:0] LOW_LAST  = PHASE_W'(PULSE_LOW_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HIGH_LAST = PHASE_W'(PULSE_HIGH_CYCLES - 1);
  localparam logic [PHASE_W-1:0] GAP_LAST  = PHASE_W'(COMMIT_GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t                state;
  logic [COIN_WIDTH-1:0] remaining;
  logic [PHASE_W-1:0]    phase;

  assign coin_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pulse_out <= 1'b1;
      done      <= 1'b0;
      reject    <= 1'b0;
      remaining <= '0;
      phase     <= '0;
    end else begin
      done   <= 1'b0;
      reject <= 1'b0;
      case (state)
        IDLE: begin
          if (coin_valid) begin
            if (coin_in == '0 || coin_in > COIN_WIDTH'(MAX_PULSE_COUNT)) begin
              reject <= 1'b1;
            end else begin
              remaining <= coin_in;
              phase     <= '0;
              pulse_out <= 1'b0;
              state     <= LOW;
            end
          end
        end
        LOW: begin
          if (phase == LOW_LAST) begin
            // The last pulse goes straight to the commit gap, skipping HIGH.
            remaining <= remaining - COIN_WIDTH'(1);
            phase     <= '0;
            pulse_out <= 1'b1;
            state     <= (remaining == COIN_WIDTH'(1)) ? GAP : HIGH;
          end else begin
            phase <= phase + PHASE_W'(1);
          end
        end
        HIGH: begin
          if (phase == HIGH_LAST) begin
            phase     <= '0;
            pulse_out <= 1'b0;
            state     <= LOW;
          end else begin
            phase <= phase + PHASE_W'(1);
          end
        end
        GAP: begin
          if (phase == GAP_LAST) begin
            phase <= '0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            phase <= phase + PHASE_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
